// File: rtl/alu_exec.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, one-bit-per-cycle serial shifter,
// and a registered branch decision for XOR-equality and SLT/SLTU compares.
module alu_exec (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  alu_ctrl,
   input  logic [1:0]  equal_comp,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        zero,
   output logic        branch_taken
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_shreg;
   logic [4:0]  r_count;
   logic [3:0]  r_op;
   logic [31:0] r_result;
   logic        r_branch;

   logic [31:0] w_alu;
   logic        w_br;
   logic        w_is_shift;
   logic        w_go_shift;
   logic [31:0] w_shifted;

   assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
   assign w_go_shift = w_is_shift && (b[4:0] != 5'd0);

   // Shift ops return a here so that a zero shift amount completes like any single-cycle op.
   always_comb begin
      w_alu = '0;
      case (alu_ctrl)
         OP_AND:  w_alu = a & b;
         OP_OR:   w_alu = a | b;
         OP_ADD:  w_alu = a + b;
         OP_SUB:  w_alu = a - b;
         OP_XOR:  w_alu = a ^ b;
         OP_SLT:  w_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: w_alu = (a < b) ? 32'd1 : 32'd0;
         OP_SLL, OP_SRL, OP_SRA: w_alu = a;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_br = 1'b0;
      if (equal_comp[1]) begin
         case (alu_ctrl)
            OP_XOR:          w_br = equal_comp[0] ? (w_alu == '0) : (w_alu != '0);
            OP_SLT, OP_SLTU: w_br = equal_comp[0] ? (w_alu != '0) : (w_alu == '0);
            default:         w_br = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_shifted = r_shreg;
      case (r_op)
         OP_SLL:  w_shifted = {r_shreg[30:0], 1'b0};
         OP_SRL:  w_shifted = {1'b0, r_shreg[31:1]};
         OP_SRA:  w_shifted = {r_shreg[31], r_shreg[31:1]};
         default: w_shifted = r_shreg;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = w_go_shift ? S_SHIFT : S_DONE;
         S_SHIFT: if (r_count == 5'd1) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shreg  <= '0;
         r_count  <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_branch <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op    <= alu_ctrl;
                  r_shreg <= a;
                  r_count <= b[4:0];
                  if (!w_go_shift) begin
                     r_result <= w_alu;
                     r_branch <= w_br;
                  end
               end
            end
            S_SHIFT: begin
               r_shreg <= w_shifted;
               r_count <= r_count - 5'd1;
               if (r_count == 5'd1) begin
                  r_result <= w_shifted;
                  r_branch <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign done         = (r_state == S_DONE);
   assign result       = r_result;
   assign zero         = (r_result == '0);
   assign branch_taken = r_branch;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table with hand-computed results and latencies,
// plus reset, abort and held-start sequences.
module tb_alu_exec;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  alu_ctrl;
   logic [1:0]  equal_comp;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        branch_taken;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [3:0]  op;
      logic [1:0]  eq;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        br;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   alu_exec dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .alu_ctrl     (alu_ctrl),
      .equal_comp   (equal_comp),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .zero         (zero),
      .branch_taken (branch_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int   cyc;
      logic busy_ok;
      logic [31:0] held;
      @(negedge clk);
      alu_ctrl   = v.op;
      equal_comp = v.eq;
      a          = v.a;
      b          = v.b;
      start      = 1'b1;
      @(posedge clk); #1;
      // scramble inputs after acceptance: must not affect the in-flight op
      start      = 1'b0;
      a          = ~v.a;
      b          = v.b ^ 32'h5;
      alu_ctrl   = 4'b0010;
      equal_comp = ~v.eq;
      cyc     = 1;
      busy_ok = 1'b1;
      while (!done && cyc < 64) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'(v.lat));
      chk({nm, "_result"}, result, v.res);
      chk({nm, "_zero"}, 32'(zero), 32'(v.z));
      chk({nm, "_branch"}, 32'(branch_taken), 32'(v.br));
      chk({nm, "_busy"}, 32'(busy & busy_ok), 32'd1);
      held = result;
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
      chk({nm, "_idle"}, 32'(busy), 32'd0);
      chk({nm, "_hold"}, result, held);
   endtask

   initial begin
      logic saw_done;
      n_cmp = 0;
      n_err = 0;

      //         op       eq     a             b             res           z     br    lat
      vecs[0]  = '{4'b0010, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[1]  = '{4'b0010, 2'b00, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1};
      vecs[2]  = '{4'b0110, 2'b00, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      vecs[3]  = '{4'b0000, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1};
      vecs[4]  = '{4'b0001, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'b0011, 2'b11, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 1};
      vecs[6]  = '{4'b0011, 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[7]  = '{4'b0011, 2'b10, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b1, 1};
      vecs[8]  = '{4'b0101, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1};
      vecs[9]  = '{4'b0111, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1};
      vecs[10] = '{4'b0101, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1};
      vecs[11] = '{4'b1001, 2'b00, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 32};
      vecs[12] = '{4'b1000, 2'b00, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 32};
      vecs[13] = '{4'b0100, 2'b00, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 1'b0, 5};
      vecs[14] = '{4'b0100, 2'b11, 32'h0000_ABCD, 32'h0000_0000, 32'h0000_ABCD, 1'b0, 1'b0, 1};
      vecs[15] = '{4'b1001, 2'b00, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0, 2};
      vecs[16] = '{4'b1111, 2'b11, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[17] = '{4'b0010, 2'b11, 32'h0000_0005, 32'h0000_0005, 32'h0000_000A, 1'b0, 1'b0, 1};
      vecs[18] = '{4'b0111, 2'b11, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1, 1};
      vecs[19] = '{4'b1000, 2'b00, 32'hF000_000F, 32'h0000_0004, 32'h0F00_0000, 1'b0, 1'b0, 5};

      // reset with start asserted: start must be discarded
      reset = 1'b1; start = 1'b1; alu_ctrl = 4'b0010; equal_comp = 2'b00;
      a = 32'h1; b = 32'h1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_branch", 32'(branch_taken), 32'd0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      saw_done = 1'b0;
      repeat (2) begin @(posedge clk); #1; saw_done |= done | busy; end
      chk("rst_start_dropped", 32'(saw_done), 32'd0);

      for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // shift aborted by reset at T+4: no done pulse, outputs back to reset values
      @(negedge clk);
      alu_ctrl = 4'b0100; equal_comp = 2'b00; a = 32'h1; b = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      saw_done = done;
      repeat (3) begin @(posedge clk); #1; saw_done |= done; end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_no_done", 32'(saw_done | done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      chk("abort_branch", 32'(branch_taken), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("abort_after_done", 32'(done), 32'd0);
      run_vec(vecs[13], "post_abort");

      // start held high: ops presented while busy are dropped, one op per 2 cycles
      @(negedge clk);
      alu_ctrl = 4'b0010; equal_comp = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
      @(posedge clk); #1;
      chk("held1_done", 32'(done), 32'd1);
      chk("held1_result", result, 32'd2);
      a = 32'd100;
      @(posedge clk); #1;
      chk("held2_done", 32'(done), 32'd0);
      chk("held2_result", result, 32'd2);
      a = 32'd10;
      @(posedge clk); #1;
      chk("held3_done", 32'(done), 32'd1);
      chk("held3_result", result, 32'd11);
      alu_ctrl = 4'b1111;
      @(posedge clk); #1;
      chk("held4_done", 32'(done), 32'd0);
      chk("held4_result", result, 32'd11);
      @(posedge clk); #1;
      chk("held5_done", 32'(done), 32'd1);
      chk("held5_result", result, 32'd0);
      chk("held5_zero", 32'(zero), 32'd1);
      start = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL be parameter-free; all widths are fixed: data 32, op 4, compare 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request; accepted only while busy=0.
REQ-005 alu_ctrl  input  4  operation code driven by alu_control (out_to_alu).
REQ-006 equal_comp  input  2  branch-compare mode driven by alu_control: 00 none, 11 branch-on-true, 10 branch-on-false, 01 treated as none.
REQ-007 a  input  32  operand A.
REQ-008 b  input  32  operand B; b[4:0] is the shift amount for shift ops.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; result, zero and branch_taken are valid in that cycle.
REQ-011 result  output  32  registered operation result.
REQ-012 zero  output  1  high when result == 0.
REQ-013 branch_taken  output  1  registered branch decision.

Function
REQ-014 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 1000 SRL, 1001 SRA, 0101 SLT (signed), 0111 SLTU (unsigned).
REQ-015 Any other alu_ctrl value SHALL produce result=0, zero=1, branch_taken=0, with non-shift timing.
REQ-016 State machine states SHALL be IDLE, SHIFT and DONE.
REQ-017 IDLE: start=1 at edge T SHALL capture a, b, alu_ctrl and equal_comp; later changes to these inputs SHALL have no effect until done.
REQ-018 Non-shift ops: IDLE->DONE at T+1; done=1 during cycle T+1 only; return to IDLE at T+2.
REQ-019 Shift ops (SLL/SRL/SRA): at T, load shift register=a and count=b[4:0].
REQ-020 Shift count 0 SHALL go IDLE->DONE (done at T+1, result=a).
REQ-021 Shift count nonzero SHALL go IDLE->SHIFT.
REQ-022 SHIFT SHALL shift the register one bit per cycle and decrement count; SRA replicates bit 31, SRL/SLL fill with 0.
REQ-023 When count reaches 0, SHIFT SHALL go to DONE; done occurs at cycle T+1+shamt (shamt 31 -> done at T+32).
REQ-024 ADD/SUB SHALL wrap modulo 2^32; no overflow or carry output.
REQ-025 SLT/SLTU SHALL produce 32'h1 or 32'h0.
REQ-026 branch_taken for XOR: equal_comp 11 -> taken iff result==0; 10 -> taken iff result!=0.
REQ-027 branch_taken for SLT/SLTU: equal_comp 11 -> taken iff result!=0; 10 -> taken iff result==0.
REQ-028 branch_taken SHALL be 0 for all other ops and for equal_comp 00 or 01.
REQ-029 result, zero and branch_taken SHALL hold their values after done until the next accepted start completes.
REQ-030 start while busy=1 (including in the DONE cycle) SHALL be ignored and not queued.
REQ-031 start in the IDLE cycle immediately after DONE SHALL be accepted normally; back-to-back throughput for non-shift ops is one op per 2 cycles.

Reset
REQ-032 reset=1 SHALL force state IDLE, busy=0, done=0, result=0, zero=1, branch_taken=0, shift register=0, count=0.
REQ-033 reset SHALL take priority over start and over any in-flight operation; an aborted shift SHALL produce no done pulse.
REQ-034 start asserted in the same cycle as reset SHALL be discarded.

Verification
REQ-035 ADD a=32'hFFFF_FFFF, b=1, start at T -> done at T+1, result=0, zero=1, branch_taken=0.
REQ-036 SRA a=32'h8000_0000, b=31 -> busy for 32 cycles, done at T+32, result=32'hFFFF_FFFF; the same with SRL -> result=1.
REQ-037 XOR a=b=32'h1234_5678, equal_comp=11 -> branch_taken=1; with equal_comp=10 -> branch_taken=0.
REQ-038 SLT a=32'hFFFF_FFFF, b=0 -> result=1, and with equal_comp=11 branch_taken=1; SLTU with the same operands -> result=0, and with equal_comp=10 branch_taken=1.
REQ-039 SLL b=10 started, reset asserted at T+4 -> no done pulse, all outputs at reset values at T+5; a new start at T+6 completes normally.
REQ-040 start held high continuously with ADD ops -> done at T+1, T+3, T+5; ops presented while busy are dropped; alu_ctrl=4'b1111 -> result=0, zero=1 at T+1.
